demo_4: RTL and testbench

Registered 8-to-3 priority encoder with active-low enable. It samples an 8-bit request vector each clock and reports the index of the highest-numbered asserted bit on `Y`. `Done` flags that `Y` holds a valid encoding. It sits between request/flag sources and downstream logic that needs a compact index of the most significant active request.

---
 rtl/demo_4.sv | 44 ++++
 tb/tb_demo_4.sv | 107 ++++++++++
 2 files changed

// File: rtl/demo_4.sv
// rtl/demo_4.sv - registered 8-to-3 priority encoder with active-low enable
// Y/Done come straight from flops; Done distinguishes "bit 0 set" from "nothing set".
module demo_4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       EN,
   input  logic [7:0] In,
   output logic [2:0] Y,
   output logic       Done
);

   logic [2:0] y_d;
   logic [2:0] y_q;
   logic       done_d;
   logic       done_q;

   // Ascending scan so the highest set bit overwrites any lower ones.
   always_comb begin
      y_d    = 3'd0;
      done_d = 1'b0;
      if (!EN) begin
         for (int i = 0; i < 8; i++) begin
            if (In[i]) begin
               y_d    = 3'(i);
               done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q    <= 3'd0;
         done_q <= 1'b0;
      end else begin
         y_q    <= y_d;
         done_q <= done_d;
      end
   end

   assign Y    = y_q;
   assign Done = done_q;

endmodule

// File: tb/tb_demo_4.sv
// tb/tb_demo_4.sv - directed self-checking bench for demo_4
module tb_demo_4;

   logic       clk;
   logic       rst_n;
   logic       EN;
   logic [7:0] In;
   logic [2:0] Y;
   logic       Done;

   int total;
   int bad;

   demo_4 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .EN    (EN),
      .In    (In),
      .Y     (Y),
      .Done  (Done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [2:0] exp_y, input logic exp_done);
      check({tag, ".Y"}, 32'(Y), 32'(exp_y));
      check({tag, ".Done"}, 32'(Done), 32'(exp_done));
   endtask

   // Drive one input set, let one rising edge sample it, look just after the edge.
   task automatic step(input logic en, input logic [7:0] in_v,
                       input logic [2:0] exp_y, input logic exp_done, input string tag);
      EN = en;
      In = in_v;
      @(posedge clk);
      #1;
      check_out(tag, exp_y, exp_done);
   endtask

   initial begin
      logic [7:0] onehot [8];
      total = 0;
      bad   = 0;
      for (int i = 0; i < 8; i++) onehot[i] = 8'(1 << i);

      rst_n = 1'b0;
      EN    = 1'b0;
      In    = 8'hFF;
      #2;
      check_out("reset_no_clk", 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check_out("reset_held", 3'd0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_out("reset_release", 3'd7, 1'b1);

      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 3'd0, 1'b0);
      rst_n = 1'b1;
      step(1'b0, 8'hFF, 3'd7, 1'b1, "after_reset");

      step(1'b1, 8'h00, 3'd0, 1'b0, "dis_00");
      step(1'b1, 8'h01, 3'd0, 1'b0, "dis_01");
      step(1'b1, 8'h80, 3'd0, 1'b0, "dis_80");
      step(1'b1, 8'hFF, 3'd0, 1'b0, "dis_ff");

      for (int i = 0; i < 8; i++)
         step(1'b0, onehot[i], 3'(i), 1'b1, $sformatf("onehot%0d", i));

      step(1'b0, 8'b0001_0110, 3'd4, 1'b1, "prio_16");
      step(1'b0, 8'b1000_0001, 3'd7, 1'b1, "prio_81");
      step(1'b0, 8'b0000_0011, 3'd1, 1'b1, "prio_03");
      step(1'b0, 8'b0110_0000, 3'd6, 1'b1, "prio_60");

      step(1'b0, 8'h00, 3'd0, 1'b0, "empty");
      step(1'b0, 8'h01, 3'd0, 1'b1, "bit0");

      step(1'b0, 8'h40, 3'd6, 1'b1, "tog_en0");
      step(1'b1, 8'h40, 3'd0, 1'b0, "tog_en1");
      step(1'b0, 8'h40, 3'd6, 1'b1, "tog_en0b");

      EN = 1'b0;
      In = 8'h20;
      #1;
      check_out("no_comb_path", 3'd6, 1'b1);
      @(posedge clk);
      #1;
      check_out("latency_one", 3'd5, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
